// File: rtl/pio_in_capture.sv
// pio_in_capture -- Avalon-MM parallel input port with per-bit edge capture
// and a level interrupt.
//
// Register map (word address):
//   0  data          RO   current (synchronised) input value
//   1  reserved      RO   reads 0
//   2  irq_mask      RW   interrupt enable per bit
//   3  edge_capture  R/W1C  sticky edge flags
//
// Ports:
//   clk         system clock, all state on posedge
//   reset_n     asynchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH ignored)
//   in_port     external inputs
//   readdata    registered read data, 1-cycle latency, zero-extended
//   irq         OR of (edge_capture & irq_mask), driven from flops only
//
// Build option: define PIO_IN_CAPTURE_SYNC_EN to put a 2-flop synchroniser
// on every input bit (input-to-capture latency 3 cycles). Without it the
// input is assumed clk-synchronous and feeds the logic directly (latency 1).
module pio_in_capture #(
    parameter int          WIDTH      = 8,
    parameter int          EDGE_TYPE  = 0,   // 0 rising, 1 falling, 2 any
    parameter logic [31:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef PIO_IN_CAPTURE_SYNC_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 0;
`endif

    typedef logic [STAGES:0] vld_t;

    vld_t             vld_pipe;
    logic             armed;
    logic             wr_en;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Edge detection stays off until prev_in holds a genuine sample of the
    // pin: the synchroniser flops (if any) must fill, then prev_in loads.
    // Without this, the reset zeros in the pipeline would look like edges
    // against an input that is already high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= vld_t'({vld_pipe, 1'b1});
    end
    assign armed = vld_pipe[STAGES];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic s_in;
        logic prev_in;
        logic edge_hit;
        logic cap;

`ifdef PIO_IN_CAPTURE_SYNC_EN
        logic sync1, sync2;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= in_port[i];
                sync2 <= sync1;
            end
        end
        assign s_in = sync2;
`else
        assign s_in = in_port[i];
`endif

        always_comb begin
            edge_hit = s_in ^ prev_in;
            if (EDGE_TYPE == 0)      edge_hit = s_in & ~prev_in;
            else if (EDGE_TYPE == 1) edge_hit = ~s_in & prev_in;
        end

        // A fresh edge wins over a simultaneous write-1-to-clear.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                prev_in <= 1'b0;
                cap     <= 1'b0;
            end else begin
                prev_in <= s_in;
                cap     <= (cap & ~clr[i]) | (edge_hit & armed);
            end
        end

        assign in_s[i]     = s_in;
        assign edge_cap[i] = cap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       irq_mask <= RESET_MASK[WIDTH-1:0];
        else if (wr_en && address == 2'd2)  irq_mask <= writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = in_s;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_cap;
            default: rd_next = '0;
        endcase
    end

    // Read data is sampled every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_capture.sv
module tb_pio_in_capture;

`ifdef PIO_IN_CAPTURE_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = '0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [7:0]  in8        = '0;
    logic [31:0] in32       = '0;
    logic [3:0]  in4        = '0;

    logic [31:0] rd_r, rd_f, rd_a, rd32, rd4;
    logic        irq_r, irq_f, irq_a, irq32, irq4;

    int tests = 0;
    int fails = 0;

    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(32'h0)) u_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in8),
        .readdata(rd_r), .irq(irq_r));
    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h0)) u_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in8),
        .readdata(rd_f), .irq(irq_f));
    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(32'h0)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in8),
        .readdata(rd_a), .irq(irq_a));
    pio_in_capture #(.WIDTH(32), .EDGE_TYPE(0), .RESET_MASK(32'h0)) u_32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in32),
        .readdata(rd32), .irq(irq32));
    pio_in_capture #(.WIDTH(4), .EDGE_TYPE(0), .RESET_MASK(32'h9)) u_4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in4),
        .readdata(rd4), .irq(irq4));

    initial forever #5 clk = ~clk;

    // ---------------- reference model (8-bit instances r/f/a) ----------------
    logic [7:0] m_cap [3];
    logic [7:0] m_mask[3];
    logic [7:0] m_prev;
    logic [7:0] m_dl[$];
    int         m_n;
    logic [31:0] m_rd[3];

    function automatic logic [7:0] edges(int k, logic [7:0] cur, logic [7:0] prv);
        if (k == 0) return cur & ~prv;
        if (k == 1) return ~cur & prv;
        return cur ^ prv;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cap[k]  = '0;
            m_mask[k] = '0;
        end
        m_prev = '0;
        m_n    = 0;
        m_dl.delete();
        for (int j = 0; j < S; j++) m_dl.push_back(8'h00);
    endtask

    // Advance the model across one clock edge using the inputs currently on
    // the pins; m_rd gets what readdata must show after that edge.
    task automatic model_step();
        logic [7:0] seen;
        logic [7:0] clr_v;
        logic       wr;
        seen = (S == 0) ? in8 : m_dl[0];
        wr   = chipselect && !write_n;
        m_n++;
        for (int k = 0; k < 3; k++) begin
            m_rd[k] = 32'h0;
            if (address == 2'd0) m_rd[k] = {24'h0, seen};
            if (address == 2'd2) m_rd[k] = {24'h0, m_mask[k]};
            if (address == 2'd3) m_rd[k] = {24'h0, m_cap[k]};
        end
        clr_v = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < 3; k++) begin
            // the pin is only genuinely sampled into prev after S+1 edges
            m_cap[k] = (m_cap[k] & ~clr_v) | ((m_n > S + 1) ? edges(k, seen, m_prev) : 8'h00);
            if (wr && address == 2'd2) m_mask[k] = writedata[7:0];
        end
        m_prev = seen;
        if (S > 0) begin
            void'(m_dl.pop_front());
            m_dl.push_back(in8);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_rd(logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic bus_wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // register-access vectors, input held at 0 so no edges occur
        tbl[0]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h0,  1'b0};
        tbl[1]  = '{2'd2, 1'b1, 1'b0, 32'hDEADBEA5, 32'h0,  1'b0};
        tbl[2]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'hA5, 1'b0};
        tbl[3]  = '{2'd0, 1'b1, 1'b0, 32'hFF,       32'h0,  1'b0};
        tbl[4]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h0,  1'b0};
        tbl[5]  = '{2'd1, 1'b1, 1'b0, 32'h77,       32'h0,  1'b0};
        tbl[6]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h0,  1'b0};
        tbl[7]  = '{2'd2, 1'b0, 1'b0, 32'h11,       32'hA5, 1'b0};
        tbl[8]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'hA5, 1'b0};
        tbl[9]  = '{2'd2, 1'b1, 1'b1, 32'h22,       32'hA5, 1'b0};
        tbl[10] = '{2'd3, 1'b1, 1'b1, 32'h0,        32'h0,  1'b0};
        tbl[11] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'hA5, 1'b0};

        // reset state while reset is held
        model_reset();
        ticks(2);
        chk("rst_rd_r", rd_r, 32'h0);
        chk("rst_rd4", rd4, 32'h0);
        chk("rst_irq", {27'h0, irq_r, irq_f, irq_a, irq32, irq4}, 32'h0);
        reset_n = 1'b1;
        bus_rd(2'd2);
        chk("rst_mask4", rd4, 32'h9);
        chk("rst_mask8", rd_r, 32'h0);

        // table-driven register access
        do_reset();
        in8 = 8'h00;
        for (int i = 0; i < 12; i++) begin
            address    = tbl[i].a;
            chipselect = tbl[i].cs;
            write_n    = tbl[i].wn;
            writedata  = tbl[i].wd;
            tick();
            chk($sformatf("tbl%0d_rd", i), rd_r, tbl[i].rd);
            chk($sformatf("tbl%0d_irq", i), {31'h0, irq_r}, {31'h0, tbl[i].irq});
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // capture latency 0x00 -> 0x5A
        do_reset();
        in8 = 8'h00;
        ticks(S + 2);
        bus_wr(2'd2, 32'hFF);
        address = 2'd3;
        in8 = 8'h5A;
        ticks(S);
        chk("lat_early_irq", {31'h0, irq_r}, 32'h0);
        tick();
        chk("lat_irq", {31'h0, irq_r}, 32'h1);
        tick();
        chk("cap_5a", rd_r, 32'h5A);
        bus_rd(2'd0);
        chk("data_5a", rd_r, 32'h5A);

        // mask 0x02 then clear bit 1
        bus_wr(2'd2, 32'h02);
        chk("irq_mask2", {31'h0, irq_r}, 32'h1);
        bus_wr(2'd3, 32'h02);
        chk("irq_clr", {31'h0, irq_r}, 32'h0);
        bus_rd(2'd3);
        chk("cap_58", rd_r, 32'h58);

        // set beats clear on the same bit and cycle
        bus_wr(2'd3, 32'h08);
        in8 = 8'h52;
        ticks(S + 2);
        bus_rd(2'd3);
        chk("no_fall_cap", rd_r, 32'h50);
        in8 = 8'h5A;
        ticks(S);
        bus_wr(2'd3, 32'h08);
        bus_rd(2'd3);
        chk("set_over_clr", rd_r, 32'h58);

        // falling / any, reset release with input high
        in8 = 8'hFF;
        do_reset();
        ticks(S + 3);
        bus_rd(2'd3);
        chk("rel_nocap_r", rd_r, 32'h0);
        chk("rel_nocap_a", rd_a, 32'h0);
        in8 = 8'h0F;
        ticks(S + 1);
        bus_rd(2'd3);
        chk("fall_f0", rd_f, 32'hF0);
        chk("fall_rise0", rd_r, 32'h0);
        chk("fall_any", rd_a, 32'hF0);

        in8 = 8'h00;
        do_reset();
        ticks(S + 2);
        in8 = 8'h01;
        tick();
        in8 = 8'h00;
        ticks(S + 2);
        bus_rd(2'd3);
        chk("pulse_any", rd_a, 32'h01);
        chk("pulse_rise", rd_r, 32'h01);
        chk("pulse_fall", rd_f, 32'h01);
        bus_wr(2'd3, 32'h01);
        ticks(S + 2);
        bus_rd(2'd3);
        chk("any_once", rd_a, 32'h0);

        // reset mid-operation while irq is high
        do_reset();
        in8 = 8'h00;
        ticks(S + 2);
        bus_wr(2'd2, 32'hFF);
        in8 = 8'hFF;
        ticks(S + 1);
        chk("pre_rst_irq", {31'h0, irq_r}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_irq_now", {31'h0, irq_r}, 32'h0);
        chk("rst_rd_now", rd_r, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ticks(S + 3);
        bus_rd(2'd3);
        chk("post_rst_cap", rd_r, 32'h0);
        bus_wr(2'd2, 32'hFF);
        chk("post_rst_irq", {31'h0, irq_r}, 32'h0);

        // width boundaries
        do_reset();
        bus_rd(2'd2);
        chk("w4_rst_mask", rd4, 32'h9);
        in4  = 4'hF;
        in32 = 32'hFFFF_FFFF;
        ticks(S);
        bus_rd(2'd0);
        chk("w4_data", rd4, 32'h0000_000F);
        chk("w32_data", rd32, 32'hFFFF_FFFF);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd1);
        chk("w32_rsvd", rd32, 32'h0);

        // randomized traffic against the model
        in8 = 8'($urandom);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) in8 = 8'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            writedata  = $urandom;
            model_step();
            tick();
            chk("rnd_rd_r", rd_r, m_rd[0]);
            chk("rnd_rd_f", rd_f, m_rd[1]);
            chk("rnd_rd_a", rd_a, m_rd[2]);
            chk("rnd_irq_r", {31'h0, irq_r}, {31'h0, |(m_cap[0] & m_mask[0])});
            chk("rnd_irq_f", {31'h0, irq_f}, {31'h0, |(m_cap[1] & m_mask[1])});
            chk("rnd_irq_a", {31'h0, irq_a}, {31'h0, |(m_cap[2] & m_mask[2])});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pio_in_capture.md
PIO_IN_CAPTURE -- requirements
Module: pio_in_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning input port width in bits, legal range 1..32.
REQ-002 SHALL provide parameter EDGE_TYPE, default 0, meaning capture edge: 0 rising, 1 falling, 2 any.
REQ-003 SHALL provide parameter RESET_MASK, default 0, meaning reset value of the irq mask register (WIDTH bits).
REQ-004 SHALL have port clk  input  1  system clock; all state on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  external asynchronous inputs.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-013 SHALL implement registers: addr 0 data (RO), addr 1 reserved (reads 0), addr 2 irq_mask (RW), addr 3 edge_capture (read; write-1-to-clear).
REQ-014 SHALL treat a write as chipselect=1 and write_n=0 in the same cycle; writes to addr 0/1 are ignored.
REQ-015 SHALL register readdata every cycle from the address mux (1-cycle latency, no wait states), independent of chipselect.
REQ-016 SHALL zero-extend all register reads; readdata[31:WIDTH] always 0.
REQ-017 SHALL keep prev_in, the last sampled value of the (possibly synchronised) input, updated every cycle.
REQ-018 SHALL detect per bit: rising = in & ~prev_in; falling = ~in & prev_in; any = in ^ prev_in; selected by EDGE_TYPE.
REQ-019 SHALL set edge_capture[i] on the cycle after edge detection and hold it until cleared.
REQ-020 SHALL clear edge_capture[i] on a write to addr 3 with writedata[i]=1; bits with writedata[i]=0 unchanged.
REQ-021 SHALL give set priority over clear when edge detection and write-1-to-clear hit the same bit in the same cycle.
REQ-022 SHALL load irq_mask from writedata[WIDTH-1:0] on a write to addr 2.
REQ-023 SHALL drive irq = OR over (edge_capture & irq_mask), combinationally from registers, with no glitch path from in_port.
REQ-024 SHALL report the data register as the current synchronised input value at read-sample time.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously set readdata=0, edge_capture=0, irq_mask=RESET_MASK, prev_in=0, and synchroniser stages=0.
REQ-026 SHALL not capture edges on the first cycle after reset release; prev_in is loaded with the input before detection becomes active.
REQ-027 SHALL drop irq to 0 immediately on reset assertion mid-operation and discard pending captures.

Configuration
REQ-028 SHALL support macro PIO_IN_CAPTURE_SYNC_EN: when defined, in_port passes a 2-flop synchroniser before data and edge logic (input-to-capture latency 3 cycles); when undefined, in_port feeds the logic directly (latency 1 cycle) and the input is treated as clk-synchronous.

Verification
REQ-029 SHALL cover: WIDTH=8, SYNC_EN defined, in_port 0x00->0x5A -> data reads 0x5A; edge_capture=0x5A exactly 3 cycles after the change.
REQ-030 SHALL cover: mask=0x02, edge_capture=0x5A -> irq=1; write 0x02 to addr 3 -> edge_capture=0x58, irq=0 on the next cycle.
REQ-031 SHALL cover: rising edge on bit 3 in the same cycle as a clear-write of 0x08 -> bit 3 remains 1.
REQ-032 SHALL cover: EDGE_TYPE=1, in_port 0xFF->0x0F -> edge_capture=0xF0; EDGE_TYPE=2 with pulse 0->1->0 on bit 0 -> bit 0 set once.
REQ-033 SHALL cover: reset_n pulsed low while irq=1, in_port=0xFF -> irq=0, readdata=0, and no capture on release.
REQ-034 SHALL cover: WIDTH=32, read addr 1 -> 0x00000000; WIDTH=4, in_port=0xF -> readdata=0x0000000F.
